// File: rtl/rename_map_unit.sv
// Two-wide register rename: speculative/architectural map tables, circular free list,
// commit-time release of superseded physical registers and flush-time recovery.
module rmu_lane #(
  parameter int PRW = 6
) (
  input  logic [4:0]     rs_l,
  input  logic [4:0]     rt_l,
  input  logic [4:0]     rd_l,
  input  logic [PRW-1:0] rs_rat,
  input  logic [PRW-1:0] rt_rat,
  input  logic [PRW-1:0] rd_rat,
  input  logic           byp_en,
  input  logic [4:0]     byp_l,
  input  logic [PRW-1:0] byp_p,
  input  logic           alloc,
  input  logic [PRW-1:0] new_p,
  output logic [PRW-1:0] rs_p,
  output logic [PRW-1:0] rt_p,
  output logic [PRW-1:0] rd_p,
  output logic [PRW-1:0] rd_old
);
  // Older slot's fresh destination overrides the map table for younger readers.
  always_comb begin
    rs_p = (byp_en && rs_l == byp_l) ? byp_p : rs_rat;
    if (rs_l == 5'd0) rs_p = '0;
    rt_p = (byp_en && rt_l == byp_l) ? byp_p : rt_rat;
    if (rt_l == 5'd0) rt_p = '0;
    rd_p   = alloc ? new_p : '0;
    rd_old = '0;
    if (alloc) rd_old = (byp_en && rd_l == byp_l) ? byp_p : rd_rat;
  end
endmodule

module rename_map_unit #(
  parameter int PRW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid1,
  input  logic           in_valid2,
  input  logic [4:0]     rs1l,
  input  logic [4:0]     rt1l,
  input  logic [4:0]     rd1l,
  input  logic [4:0]     rs2l,
  input  logic [4:0]     rt2l,
  input  logic [4:0]     rd2l,
  input  logic           rd1_en,
  input  logic           rd2_en,
  output logic           ren_ready,
  output logic           out_valid1,
  output logic           out_valid2,
  output logic [PRW-1:0] rs1p,
  output logic [PRW-1:0] rt1p,
  output logic [PRW-1:0] rd1p,
  output logic [PRW-1:0] rd1old,
  output logic [PRW-1:0] rs2p,
  output logic [PRW-1:0] rt2p,
  output logic [PRW-1:0] rd2p,
  output logic [PRW-1:0] rd2old,
  input  logic           cm_en1,
  input  logic           cm_en2,
  input  logic [4:0]     cm_rdl1,
  input  logic [4:0]     cm_rdl2,
  input  logic [PRW-1:0] cm_rdp1,
  input  logic [PRW-1:0] cm_rdp2,
  input  logic           flush
);
  localparam int NP = 2**PRW;
  localparam int FD = NP - 32;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);

  logic [PRW-1:0] srat_q [32];
  logic [PRW-1:0] arch_q [32];
  logic [PRW-1:0] arch_d [32];
  logic [PRW-1:0] fl_q   [FD];
  logic [PW-1:0]  head_q, chead_q, tail_q, chead_d, tail2;
  logic [CW-1:0]  free_q, free_d;

  logic [1:0][4:0]     rs_l, rt_l, rd_l;
  logic [1:0]          rd_en, vld, alloc;
  logic [1:0][PRW-1:0] new_p, ln_rs, ln_rt, ln_rd, ln_old;
  logic [1:0]          n_alloc, n_cm;
  logic [PRW-1:0]      push1, push2;
  logic                acc;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(n);
    if (s >= (PW+1)'(FD)) s = s - (PW+1)'(FD);
    return s[PW-1:0];
  endfunction

  assign rs_l  = {rs2l, rs1l};
  assign rt_l  = {rt2l, rt1l};
  assign rd_l  = {rd2l, rd1l};
  assign rd_en = {rd2_en, rd1_en};

  assign ren_ready = (free_q >= CW'(2)) && !flush;
  assign acc       = ren_ready && in_valid1;
  assign vld       = {acc && in_valid2, acc};

  always_comb begin
    for (int k = 0; k < 2; k++) alloc[k] = vld[k] && rd_en[k] && (rd_l[k] != 5'd0);
  end

  assign new_p[0] = fl_q[head_q];
  assign new_p[1] = fl_q[ptr_add(head_q, {1'b0, alloc[0]})];
  assign n_alloc  = {1'b0, alloc[0]} + {1'b0, alloc[1]};

  generate
    for (genvar k = 0; k < 2; k++) begin : g_lane
      logic           byp_en;
      logic [4:0]     byp_l;
      logic [PRW-1:0] byp_p;
      if (k == 0) begin : g_oldest
        assign byp_en = 1'b0;
        assign byp_l  = '0;
        assign byp_p  = '0;
      end else begin : g_younger
        assign byp_en = alloc[k-1];
        assign byp_l  = rd_l[k-1];
        assign byp_p  = new_p[k-1];
      end
      rmu_lane #(.PRW(PRW)) u_lane (
        .rs_l(rs_l[k]), .rt_l(rt_l[k]), .rd_l(rd_l[k]),
        .rs_rat(srat_q[rs_l[k]]), .rt_rat(srat_q[rt_l[k]]), .rd_rat(srat_q[rd_l[k]]),
        .byp_en(byp_en), .byp_l(byp_l), .byp_p(byp_p),
        .alloc(alloc[k]), .new_p(new_p[k]),
        .rs_p(ln_rs[k]), .rt_p(ln_rt[k]), .rd_p(ln_rd[k]), .rd_old(ln_old[k])
      );
    end
  endgenerate

  // Second commit to the same logical register releases the first commit's mapping.
  always_comb begin
    push1 = arch_q[cm_rdl1];
    push2 = (cm_en1 && cm_rdl2 == cm_rdl1) ? cm_rdp1 : arch_q[cm_rdl2];
    for (int i = 0; i < 32; i++) arch_d[i] = arch_q[i];
    if (cm_en1) arch_d[cm_rdl1] = cm_rdp1;
    if (cm_en2) arch_d[cm_rdl2] = cm_rdp2;
    n_cm    = {1'b0, cm_en1} + {1'b0, cm_en2};
    chead_d = ptr_add(chead_q, n_cm);
    tail2   = ptr_add(tail_q, {1'b0, cm_en1});
    free_d  = free_q - CW'(n_alloc) + CW'(n_cm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        srat_q[i] <= PRW'(i);
        arch_q[i] <= PRW'(i);
      end
      for (int j = 0; j < FD; j++) fl_q[j] <= PRW'(32 + j);
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= '0;
      free_q  <= CW'(FD);
    end else begin
      for (int i = 0; i < 32; i++) arch_q[i] <= arch_d[i];
      if (cm_en1) fl_q[tail_q] <= push1;
      if (cm_en2) fl_q[tail2]  <= push2;
      tail_q  <= ptr_add(tail_q, n_cm);
      chead_q <= chead_d;
      if (flush) begin
        for (int i = 0; i < 32; i++) srat_q[i] <= arch_d[i];
        head_q <= chead_d;
        free_q <= CW'(FD);
      end else begin
        if (alloc[0]) srat_q[rd1l] <= new_p[0];
        if (alloc[1]) srat_q[rd2l] <= new_p[1];
        head_q <= ptr_add(head_q, n_alloc);
        free_q <= free_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid1 <= 1'b0;
      out_valid2 <= 1'b0;
      rs1p <= '0; rt1p <= '0; rd1p <= '0; rd1old <= '0;
      rs2p <= '0; rt2p <= '0; rd2p <= '0; rd2old <= '0;
    end else begin
      out_valid1 <= vld[0];
      out_valid2 <= vld[1];
      if (acc) begin
        rs1p <= ln_rs[0]; rt1p <= ln_rt[0]; rd1p <= ln_rd[0]; rd1old <= ln_old[0];
        rs2p <= ln_rs[1]; rt2p <= ln_rt[1]; rd2p <= ln_rd[1]; rd2old <= ln_old[1];
      end
    end
  end
endmodule

// File: tb/tb_rename_map_unit.sv
// Directed bench for rename_map_unit: a queue-based free-list/map model predicts each
// renamed group, expectations are queued at drive time and checked after the edge.
module tb_rename_map_unit;
  localparam int PRW = 6;

  logic clk = 1'b0;
  logic rst;
  logic in_valid1, in_valid2, rd1_en, rd2_en;
  logic [4:0] rs1l, rt1l, rd1l, rs2l, rt2l, rd2l;
  logic ren_ready, out_valid1, out_valid2;
  logic [PRW-1:0] rs1p, rt1p, rd1p, rd1old, rs2p, rt2p, rd2p, rd2old;
  logic cm_en1, cm_en2, flush;
  logic [4:0] cm_rdl1, cm_rdl2;
  logic [PRW-1:0] cm_rdp1, cm_rdp2;

  always #5 clk = ~clk;

  rename_map_unit #(.PRW(PRW)) dut (
    .clk(clk), .rst(rst),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .rs1l(rs1l), .rt1l(rt1l), .rd1l(rd1l), .rs2l(rs2l), .rt2l(rt2l), .rd2l(rd2l),
    .rd1_en(rd1_en), .rd2_en(rd2_en), .ren_ready(ren_ready),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .rs1p(rs1p), .rt1p(rt1p), .rd1p(rd1p), .rd1old(rd1old),
    .rs2p(rs2p), .rt2p(rt2p), .rd2p(rd2p), .rd2old(rd2old),
    .cm_en1(cm_en1), .cm_en2(cm_en2), .cm_rdl1(cm_rdl1), .cm_rdl2(cm_rdl2),
    .cm_rdp1(cm_rdp1), .cm_rdp2(cm_rdp2), .flush(flush)
  );

  typedef struct {
    bit v1, v2;
    int rs1, rt1, rd1, o1, rs2, rt2, rd2, o2;
  } exp_t;

  exp_t sb[$];
  int   srat[32];
  int   arch[32];
  int   fl[$];
  int   inf[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      srat[i] = i;
      arch[i] = i;
    end
    fl.delete();
    inf.delete();
    sb.delete();
    for (int j = 0; j < 32; j++) fl.push_back(32 + j);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid1 = 0; in_valid2 = 0; rd1_en = 0; rd2_en = 0;
    rs1l = 0; rt1l = 0; rd1l = 0; rs2l = 0; rt2l = 0; rd2l = 0;
    cm_en1 = 0; cm_en2 = 0; cm_rdl1 = 0; cm_rdl2 = 0; cm_rdp1 = 0; cm_rdp2 = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid1", 32'(out_valid1), 0);
    chk("rst_out_valid2", 32'(out_valid2), 0);
    chk("rst_rd1p", 32'(rd1p), 0);
    chk("rst_rd2old", 32'(rd2old), 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_ren_ready", 32'(ren_ready), 1);
  endtask

  // One clock: drive a group plus commit/flush, predict, then check after the edge.
  task automatic step(input bit v1, input int as, input int at, input int ad, input bit e1,
                      input bit v2, input int bs, input int bt, input int bd, input bit e2,
                      input bit c1, input int cl1, input int cp1,
                      input bit c2, input int cl2, input int cp2, input bit fl_i);
    exp_t e;
    bit rdy, a1, a2;
    int old;
    in_valid1 = v1; rs1l = 5'(as); rt1l = 5'(at); rd1l = 5'(ad); rd1_en = e1;
    in_valid2 = v2; rs2l = 5'(bs); rt2l = 5'(bt); rd2l = 5'(bd); rd2_en = e2;
    cm_en1 = c1; cm_rdl1 = 5'(cl1); cm_rdp1 = PRW'(cp1);
    cm_en2 = c2; cm_rdl2 = 5'(cl2); cm_rdp2 = PRW'(cp2);
    flush = fl_i;
    #2;
    rdy = (fl.size() >= 2) && !fl_i;
    chk("ren_ready", 32'(ren_ready), 32'(rdy));
    e = '{default: 0};
    e.v1 = rdy && v1;
    e.v2 = e.v1 && v2;
    a1 = e.v1 && e1 && ad != 0;
    a2 = e.v2 && e2 && bd != 0;
    e.rd1 = a1 ? fl.pop_front() : 0;
    e.rd2 = a2 ? fl.pop_front() : 0;
    e.rs1 = (as == 0) ? 0 : srat[as];
    e.rt1 = (at == 0) ? 0 : srat[at];
    e.o1  = a1 ? srat[ad] : 0;
    if (a1) begin
      srat[ad] = e.rd1;
      inf.push_back(e.rd1);
    end
    e.rs2 = (bs == 0) ? 0 : srat[bs];
    e.rt2 = (bt == 0) ? 0 : srat[bt];
    e.o2  = a2 ? srat[bd] : 0;
    if (a2) begin
      srat[bd] = e.rd2;
      inf.push_back(e.rd2);
    end
    if (c1) begin
      old = arch[cl1]; fl.push_back(old); arch[cl1] = cp1; void'(inf.pop_front());
    end
    if (c2) begin
      old = arch[cl2]; fl.push_back(old); arch[cl2] = cp2; void'(inf.pop_front());
    end
    if (fl_i) begin
      srat = arch;
      fl = {inf, fl};
      inf.delete();
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_valid1", 32'(out_valid1), 32'(e.v1));
    chk("out_valid2", 32'(out_valid2), 32'(e.v2));
    if (e.v1) begin
      chk("rs1p", 32'(rs1p), e.rs1); chk("rt1p", 32'(rt1p), e.rt1);
      chk("rd1p", 32'(rd1p), e.rd1); chk("rd1old", 32'(rd1old), e.o1);
    end
    if (e.v2) begin
      chk("rs2p", 32'(rs2p), e.rs2); chk("rt2p", 32'(rt2p), e.rt2);
      chk("rd2p", 32'(rd2p), e.rd2); chk("rd2old", 32'(rd2old), e.o2);
    end
  endtask

  task automatic grp(input int as, input int at, input int ad, input int bs, input int bt, input int bd);
    step(1, as, at, ad, 1, 1, bs, bt, bd, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    do_reset();

    // First group straight out of reset.
    grp(0, 1, 3, 2, 7, 4);
    chk("first_rs1p", 32'(rs1p), 0);
    chk("first_rd1p", 32'(rd1p), 32);
    chk("first_rd2p", 32'(rd2p), 33);
    chk("first_rd1old", 32'(rd1old), 3);
    chk("first_rd2old", 32'(rd2old), 4);

    // Intra-group dependency on r5.
    grp(1, 2, 5, 5, 5, 5);
    chk("dep_rs2p", 32'(rs2p), 34);
    chk("dep_rt2p", 32'(rt2p), 34);
    chk("dep_rd2old", 32'(rd2old), 34);
    chk("dep_rd2p", 32'(rd2p), 35);

    // r0 destination, disabled destination, slot 2 without slot 1.
    step(1, 5, 3, 0, 1, 1, 4, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rat5_is_rd2p", 32'(rs1p), 35);
    step(0, 1, 1, 1, 1, 1, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0);

    // Drain the free list: 14 more allocating pairs makes 16.
    for (int i = 0; i < 14; i++)
      grp(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1 + (2 * i) % 31,
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1 + (2 * i + 1) % 31);
    chk("drained_ren_ready", 32'(ren_ready), 0);
    grp(1, 2, 3, 4, 5, 6);

    // Commits refill; physical 3 and 4 come back round after the wrap.
    step(1, 1, 2, 3, 1, 1, 4, 5, 6, 1, 1, 3, 32, 0, 0, 0, 0);
    step(1, 1, 2, 3, 1, 1, 4, 5, 6, 1, 1, 4, 33, 0, 0, 0, 0);
    grp(1, 2, 10, 4, 5, 11);
    chk("wrap_rd1p", 32'(rd1p), 3);
    chk("wrap_rd2p", 32'(rd2p), 4);

    // Flush after three groups with one committed.
    do_reset();
    grp(0, 0, 1, 0, 0, 2);
    grp(1, 2, 3, 3, 1, 4);
    grp(3, 4, 5, 5, 2, 6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    grp(1, 2, 7, 3, 6, 8);
    chk("flush_rs1p", 32'(rs1p), 32);
    chk("flush_rt1p", 32'(rt1p), 2);
    chk("flush_rd1p", 32'(rd1p), 33);

    // Flush together with a commit; the presented group is dropped.
    step(1, 1, 2, 9, 1, 1, 3, 4, 10, 1, 1, 7, 33, 0, 0, 0, 1);
    grp(7, 8, 9, 9, 0, 9);
    chk("fc_rs1p", 32'(rs1p), 33);
    chk("fc_rt1p", 32'(rt1p), 8);
    chk("fc_rd1p", 32'(rd1p), 34);
    chk("fc_rd2old", 32'(rd2old), 34);

    // Both commits to r9: frees 9 and 34.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 34, 1, 9, 35, 0);

    // Random drain through the wrap to see the recycled registers.
    for (int i = 0; i < 24; i++)
      step(bit'($urandom_range(0, 7) != 0), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), bit'($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
